// File: rtl/time_entry.sv
// Button-driven MM:SS time-entry block: conditions four raw buttons, edits one BCD
// digit at a time under a blinking cursor, and strobes the entered time to the counter.
module time_entry #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int BLINK_HALF      = 12500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_sel,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       btn_load,
    input  logic       run_busy,
    output logic [3:0] min_10,
    output logic [3:0] min_1,
    output logic [3:0] sec_10,
    output logic [3:0] sec_1,
    output logic [1:0] cursor,
    output logic [3:0] blink_mask,
    output logic       load,
    output logic       zero_err
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BKW = $clog2(BLINK_HALF + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BKW-1:0] BK_LAST = BKW'(BLINK_HALF - 1);

    localparam int B_SEL  = 0;
    localparam int B_INC  = 1;
    localparam int B_DEC  = 2;
    localparam int B_LOAD = 3;

    typedef enum logic [1:0] {
        EDIT = 2'd0,
        LOAD = 2'd1,
        LOCK = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [3:0]     btn_raw;
    logic [3:0]     sync1, sync2;
    logic [3:0]     stable, stable_d;
    logic [3:0]     evt;
    logic [DBW-1:0] db_cnt [4];

    logic [3:0]     dig [4];
    logic [3:0]     dig_lim;
    logic           all_zero;
    logic           edit_ok;
    logic [1:0]     lock_cnt;
    logic           busy_seen;

    logic [BKW-1:0] blink_cnt;
    logic           phase;

    assign btn_raw = {btn_load, btn_dec, btn_inc, btn_sel};

    // Sync, debounce and edge-detect. The counter only runs while the synced level
    // disagrees with the accepted level, so any bounce back restarts it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_d <= '0;
            evt      <= '0;
            // NOTE: this array is four small counters, not a RAM, so it is reset
            // like any other state; a real memory would be left unreset.
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            // NOTE: every register here is assigned with <=, so all of them sample
            // the values from before this edge regardless of statement order.
            sync1    <= btn_raw;
            sync2    <= sync1;
            stable_d <= stable;
            evt      <= stable & ~stable_d;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign all_zero = ((dig[0] | dig[1] | dig[2] | dig[3]) == 4'd0);
    assign edit_ok  = (state == EDIT) && !run_busy;
    assign dig_lim  = cursor[0] ? 4'd5 : 4'd9;

    always_ff @(posedge clk) begin
        if (!reset) state <= EDIT;
        else        state <= state_nx;
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal
        // unassigned, which would otherwise infer a latch.
        state_nx = state;
        load     = 1'b0;
        case (state)
            EDIT: begin
                if (edit_ok && evt[B_LOAD] && !all_zero) state_nx = LOAD;
            end
            LOAD: begin
                load     = 1'b1;
                state_nx = LOCK;
            end
            LOCK: begin
                if (!run_busy && (busy_seen || lock_cnt == 2'd3)) state_nx = EDIT;
            end
            default: state_nx = EDIT;
        endcase
    end

    // Digit/cursor editing and LOCK bookkeeping. Load outranks sel, sel outranks
    // inc, inc outranks dec; lower-priority events in the same cycle are dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) dig[i] <= 4'd0;
            cursor    <= 2'd0;
            zero_err  <= 1'b0;
            lock_cnt  <= 2'd0;
            busy_seen <= 1'b0;
        end else begin
            zero_err <= 1'b0;
            if (state == LOCK) begin
                lock_cnt <= lock_cnt + 2'd1;
                if (run_busy) busy_seen <= 1'b1;
            end else begin
                lock_cnt  <= 2'd0;
                busy_seen <= 1'b0;
            end
            if (edit_ok) begin
                if (evt[B_LOAD]) begin
                    zero_err <= all_zero;
                end else if (evt[B_SEL]) begin
                    cursor <= cursor + 2'd1;
                end else if (evt[B_INC]) begin
                    dig[cursor] <= (dig[cursor] >= dig_lim) ? 4'd0 : dig[cursor] + 4'd1;
                end else if (evt[B_DEC]) begin
                    dig[cursor] <= (dig[cursor] == 4'd0 || dig[cursor] > dig_lim)
                                   ? dig_lim : dig[cursor] - 4'd1;
                end
            end
        end
    end

    // Blink phase restarts visible on any edit-type event so the digit never
    // vanishes right after the user touches it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            blink_cnt  <= '0;
            phase      <= 1'b0;
            blink_mask <= 4'd0;
        end else begin
            if (|evt[B_DEC:B_SEL]) begin
                blink_cnt <= '0;
                phase     <= 1'b0;
            end else if (blink_cnt == BK_LAST) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
            blink_mask <= (state == EDIT && phase) ? (4'b0001 << cursor) : 4'b0000;
        end
    end

    assign sec_1  = dig[0];
    assign sec_10 = dig[1];
    assign min_1  = dig[2];
    assign min_10 = dig[3];

endmodule
